// File: rtl/ss_arb_pkg.sv
// ss_arb_pkg: shared types and constants for the simulation-slave-bus arbiter.
// Used by ss_bus_arbiter, ss_arb_timeout and the bench.
package ss_arb_pkg;

  localparam int NUM_MASTERS = 2;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ADDR = 2'd1,
    ST_RESP = 2'd2
  } state_e;

  typedef logic master_idx_t;

  // Slave-side address map of zeroriscy_sim_top.
  localparam logic [31:0] UART_BASE   = 32'h9a10_0000;
  localparam logic [31:0] TOHOST_BASE = 32'h8000_1000;

  // Winner of an arbitration round: the lone requester, or the round-robin
  // pointer when both masters request together.
  function automatic master_idx_t rr_pick(input logic [NUM_MASTERS-1:0] req,
                                          input master_idx_t            rr);
    if (req == 2'b11) return rr;
    if (req[1])       return 1'b1;
    return 1'b0;
  endfunction

endpackage

// File: rtl/ss_arb_timeout.sv
// ss_arb_timeout: wait-cycle counter for the arbiter's ADDR/RESP phases.
// Flags expiry on the TIMEOUT-th cycle after the last clear; only built when
// SS_ARB_TIMEOUT_EN is defined.
module ss_arb_timeout #(
  parameter int unsigned TIMEOUT = 1024
) (
  input  logic clk,
  input  logic reset,
  input  logic i_clear,
  input  logic i_run,
  output logic o_expired
);

  localparam int unsigned   CW   = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [CW-1:0] LAST = CW'(TIMEOUT - 1);

  logic [CW-1:0] r_count;

  // Count wait cycles, restarting on each phase entry and holding at the limit.
  always_ff @(posedge clk or posedge reset) begin
    // NOTE: clocked state is written with <= so every flop samples pre-edge values.
    if (reset)                          r_count <= '0;
    else if (i_clear)                   r_count <= '0;
    else if (i_run && r_count != LAST)  r_count <= r_count + 1'b1;
  end

  assign o_expired = i_run && (r_count == LAST);

endmodule

// File: rtl/ss_bus_arbiter.sv
// ss_bus_arbiter: two-master, one-slave arbiter for the ss_* simulation bus.
// Master 0 is the core data port, master 1 the host loader. One outstanding
// transaction, round-robin between simultaneous requesters, req/gnt/rvalid/err
// handshake. Define SS_ARB_TIMEOUT_EN to add a forced-error timeout.
module ss_bus_arbiter
  import ss_arb_pkg::*;
#(
  parameter int unsigned AW      = 32,
  parameter int unsigned DW      = 32,
  parameter int unsigned TIMEOUT = 1024
) (
  input  logic                                clk,
  input  logic                                reset,
  input  logic [NUM_MASTERS-1:0]              m_req,
  input  logic [NUM_MASTERS-1:0]              m_we,
  input  logic [NUM_MASTERS-1:0][DW/8-1:0]    m_be,
  input  logic [NUM_MASTERS-1:0][AW-1:0]      m_addr,
  input  logic [NUM_MASTERS-1:0][DW-1:0]      m_wdata,
  output logic [NUM_MASTERS-1:0]              m_gnt,
  output logic [NUM_MASTERS-1:0]              m_rvalid,
  output logic [DW-1:0]                       m_rdata,
  output logic                                m_err,
  output logic                                ss_req,
  output logic                                ss_we,
  output logic [DW/8-1:0]                     ss_be,
  output logic [AW-1:0]                       ss_addr,
  output logic [DW-1:0]                       ss_wdata,
  input  logic                                ss_gnt,
  input  logic                                ss_rvalid,
  input  logic [DW-1:0]                       ss_rdata,
  input  logic                                ss_err
);

  state_e      r_state, w_state_nxt;
  master_idx_t r_owner, w_owner_nxt;
  master_idx_t r_rr,    w_rr_nxt;

  logic w_expired;     // timeout counter reached its limit this cycle
  logic w_pending;     // ADDR timed out; RESP must answer with an error
  logic w_addr_tmo;
  logic w_resp_force;
  logic w_in_addr;
  logic w_in_resp;
  logic w_gnt_any;
  logic w_rsp_any;

  assign w_in_addr    = (r_state == ST_ADDR);
  assign w_in_resp    = (r_state == ST_RESP);
  assign w_addr_tmo   = w_in_addr && w_expired;
  assign w_resp_force = w_in_resp && (w_expired || w_pending);
  assign w_gnt_any    = w_in_addr && m_req[r_owner] && (ss_gnt || w_addr_tmo);
  assign w_rsp_any    = w_in_resp && (ss_rvalid || w_resp_force);

`ifdef SS_ARB_TIMEOUT_EN
  logic r_pending;
  logic w_tmo_clear;

  assign w_tmo_clear = (w_state_nxt != r_state) && (w_state_nxt != ST_IDLE);

  ss_arb_timeout #(.TIMEOUT(TIMEOUT)) u_timeout (
    .clk       (clk),
    .reset     (reset),
    .i_clear   (w_tmo_clear),
    .i_run     (r_state != ST_IDLE),
    .o_expired (w_expired)
  );

  // Remember a grant forced by timeout so RESP reports an error immediately.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)                                          r_pending <= 1'b0;
    else if (w_in_addr && w_state_nxt == ST_RESP)       r_pending <= w_expired && !ss_gnt;
    else if (w_in_resp && w_state_nxt == ST_IDLE)       r_pending <= 1'b0;
  end

  assign w_pending = r_pending;
`else
  assign w_expired = 1'b0;
  assign w_pending = 1'b0;
`endif

  // Next-state, owner and round-robin pointer decisions.
  always_comb begin
    // NOTE: every variable gets a default first so no path leaves it unassigned (no latch).
    w_state_nxt = r_state;
    w_owner_nxt = r_owner;
    w_rr_nxt    = r_rr;
    unique case (r_state)
      ST_IDLE: begin
        if (|m_req) begin
          w_owner_nxt = rr_pick(m_req, r_rr);
          w_state_nxt = ST_ADDR;
        end
      end
      ST_ADDR: begin
        if (!m_req[r_owner]) begin
          w_state_nxt = ST_IDLE;   // requester withdrew before grant
        end else if (ss_gnt || w_addr_tmo) begin
          w_state_nxt = ST_RESP;
          w_rr_nxt    = ~r_owner;
        end
      end
      ST_RESP: begin
        if (w_rsp_any) w_state_nxt = ST_IDLE;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // FSM, owner and pointer registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= ST_IDLE;
      r_owner <= 1'b0;
      r_rr    <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_owner <= w_owner_nxt;
      r_rr    <= w_rr_nxt;
    end
  end

  // Slave request path: owner's fields pass through only while in ADDR.
  always_comb begin
    ss_req   = w_in_addr && m_req[r_owner];
    ss_we    = 1'b0;
    ss_be    = '0;
    ss_addr  = '0;
    ss_wdata = '0;
    if (w_in_addr) begin
      ss_we    = m_we[r_owner];
      ss_be    = m_be[r_owner];
      ss_addr  = m_addr[r_owner];
      ss_wdata = m_wdata[r_owner];
    end
  end

  // Master-side grant and response steering to the current owner.
  always_comb begin
    m_gnt            = '0;
    m_rvalid         = '0;
    m_gnt[r_owner]   = w_gnt_any;
    m_rvalid[r_owner] = w_rsp_any;
    m_rdata          = (w_rsp_any && !w_resp_force) ? ss_rdata : '0;
    m_err            = w_rsp_any && (w_resp_force || ss_err);
  end

endmodule
